// File: rtl/ram_pkg.sv
// Shared definitions for initiators of the 128x8 single-port synchronous RAM.
package ram_pkg;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ram_state_e;

endpackage

// File: rtl/ram_copier.sv
// Block copy sequencer driving a single-port RAM; fill mode is compiled in
// with the RAM_COPIER_FILL_EN macro.
module ram_copier
  import ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ram_pkg::AW-1:0] src_addr,
  input  logic [ram_pkg::AW-1:0] dst_addr,
  input  logic [ram_pkg::AW:0]   len,
  input  logic                 fill,
  input  logic [ram_pkg::DW-1:0] pattern,
  output logic                 busy,
  output logic                 done,
  output logic [ram_pkg::AW-1:0] mem_addr,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ram_pkg::DW-1:0] mem_wdata,
  input  logic [ram_pkg::DW-1:0] mem_rdata
);

  ram_state_e    state_q, state_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_next;
  logic [AW:0]   len_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;

`ifdef RAM_COPIER_FILL_EN
  logic          fill_q;
  logic [DW-1:0] pat_q;
`else
  logic          unused_fill_inputs;
  assign unused_fill_inputs = ^{fill, pattern};
`endif

  assign cnt_next = cnt_q + {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
`ifdef RAM_COPIER_FILL_EN
      fill_q  <= 1'b0;
      pat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        // Request parameters are captured once; inputs may change afterwards.
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len;
        cnt_q <= '0;
`ifdef RAM_COPIER_FILL_EN
        fill_q <= fill;
        pat_q  <= pattern;
`endif
      end else if (state_q == WRITE) begin
        cnt_q <= cnt_next;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0)
            state_d = DONE;
`ifdef RAM_COPIER_FILL_EN
          else if (fill)
            state_d = WRITE;
`endif
          else
            state_d = READ;
        end
      end
      READ:  state_d = WRITE;
      WRITE: begin
        if (cnt_next < len_q) begin
`ifdef RAM_COPIER_FILL_EN
          state_d = fill_q ? WRITE : READ;
`else
          state_d = READ;
`endif
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, so start never reaches the RAM port.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      READ: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = src_q + cnt_q[AW-1:0];
      end
      WRITE: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dst_q + cnt_q[AW-1:0];
`ifdef RAM_COPIER_FILL_EN
        mem_wdata = fill_q ? pat_q : mem_rdata;
`else
        mem_wdata = mem_rdata;
`endif
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_copier.sv
// Self-checking bench for ram_copier with a behavioural 128x8 RAM behind it.
module tb_ram_copier;
  import ram_pkg::*;

  localparam int K_IDLE  = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int        kind;
    int        addr;
    int        src;
    bit        is_fill;
    logic [7:0] pat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] src_addr = '0;
  logic [6:0] dst_addr = '0;
  logic [7:0] len = '0;
  logic       fill = 1'b0;
  logic [7:0] pattern = '0;
  logic       busy, done, mem_en, mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;

  logic [7:0] ram [0:127];
  logic [7:0] model_mem [0:127];
  logic [7:0] snap [0:127];

  logic       bd_en = 1'b0;
  logic [6:0] bd_addr = '0;
  logic [7:0] bd_data = '0;

  exp_t q[$];
  bit   cur_idle = 1'b1;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   en_cnt = 0;
  int   rd_cnt = 0;

  ram_copier dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill(fill), .pattern(pattern), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Responder RAM with one-cycle registered read and a backdoor port for preloads.
  always @(posedge clk) begin
    if (bd_en)
      ram[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic [7:0] init_val(int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Request model: a request becomes a list of per-cycle memory operations.
  always @(posedge clk) begin
    if (!rst) q.delete();
    else if (start && cur_idle) begin
      int n;
      n = int'(len);
      for (int k = 0; k < n; k++) begin
        exp_t r, w;
        bit f;
        f = 1'b0;
`ifdef RAM_COPIER_FILL_EN
        f = fill;
`endif
        r = '{K_READ, (int'(src_addr) + k) % 128, 0, 1'b0, 8'h00};
        w = '{K_WRITE, (int'(dst_addr) + k) % 128, (int'(src_addr) + k) % 128, f, pattern};
        if (!f) q.push_back(r);
        q.push_back(w);
      end
      q.push_back('{K_DONE, 0, 0, 1'b0, 8'h00});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] wd;
    if (bd_en) model_mem[bd_addr] = bd_data;
    if (q.size() > 0) e = q.pop_front();
    else              e = '{K_IDLE, 0, 0, 1'b0, 8'h00};
    cur_idle = (e.kind == K_IDLE);
    if (chk_en) begin
      wd = 8'h00;
      if (e.kind == K_WRITE) begin
        wd = e.is_fill ? e.pat : model_mem[e.src];
        model_mem[e.addr] = wd;
      end
      check_output("busy", 32'(busy), 32'(e.kind == K_READ || e.kind == K_WRITE));
      check_output("done", 32'(done), 32'(e.kind == K_DONE));
      check_output("mem_en", 32'(mem_en), 32'(e.kind == K_READ || e.kind == K_WRITE));
      check_output("mem_we", 32'(mem_we), 32'(e.kind == K_WRITE));
      check_output("mem_addr", 32'(mem_addr), 32'(e.addr));
      if (e.kind != K_READ) check_output("mem_wdata", 32'(mem_wdata), 32'(wd));
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (mem_en === 1'b1) en_cnt++;
      if (mem_en === 1'b1 && mem_we === 1'b0) rd_cnt++;
    end
  end

  task automatic poke(input int a, input logic [7:0] d);
    @(posedge clk); #1;
    bd_en = 1'b1; bd_addr = 7'(a); bd_data = d;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  task automatic apply_stimulus(input int s, input int d, input int n, input bit f, input logic [7:0] p);
    @(posedge clk); #1;
    busy_cnt = 0; done_cnt = 0; en_cnt = 0; rd_cnt = 0;
    @(negedge clk);
    src_addr = 7'(s); dst_addr = 7'(d); len = 8'(n); fill = f; pattern = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      if (q.size() == 0 && cur_idle) begin ok = 1'b1; break; end
    end
    check_output("idle_timeout", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_model_mem();
    int diffs;
    diffs = 0;
    for (int a = 0; a < 128; a++) if (ram[a] !== model_mem[a]) diffs++;
    check_output("mem_vs_model", 32'(diffs), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin
      ram[a] = init_val(a);
      model_mem[a] = init_val(a);
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_en", 32'(mem_en), 32'd0);
    check_output("reset_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;

    // Basic copy
    for (int k = 0; k < 4; k++) poke(10 + k, 8'hA0 + 8'(k));
    apply_stimulus(10, 50, 4, 1'b0, 8'h00);
    wait_idle();
    check_output("copy_busy_cycles", 32'(busy_cnt), 32'd8);
    check_output("copy_done_pulses", 32'(done_cnt), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_output("copy_dst", 32'(ram[50 + k]), 32'(8'hA0 + k));
      check_output("copy_src_kept", 32'(ram[10 + k]), 32'(8'hA0 + k));
    end
    check_model_mem();

    // Source wraps past the top of memory
    poke(126, 8'h11); poke(127, 8'h22); poke(0, 8'h33);
    apply_stimulus(126, 60, 3, 1'b0, 8'h00);
    wait_idle();
    check_output("wrap_src_0", 32'(ram[60]), 32'h11);
    check_output("wrap_src_1", 32'(ram[61]), 32'h22);
    check_output("wrap_src_2", 32'(ram[62]), 32'h33);
    apply_stimulus(60, 127, 2, 1'b0, 8'h00);
    wait_idle();
    check_output("wrap_dst_127", 32'(ram[127]), 32'h11);
    check_output("wrap_dst_0", 32'(ram[0]), 32'h22);
    check_model_mem();

    // Zero length
    apply_stimulus(5, 6, 0, 1'b0, 8'h00);
    wait_idle();
    check_output("len0_busy", 32'(busy_cnt), 32'd0);
    check_output("len0_en", 32'(en_cnt), 32'd0);
    check_output("len0_done", 32'(done_cnt), 32'd1);

    // Whole memory onto itself
    for (int a = 0; a < 128; a++) snap[a] = ram[a];
    apply_stimulus(0, 0, 128, 1'b0, 8'h00);
    wait_idle();
    check_output("full_busy_cycles", 32'(busy_cnt), 32'd256);
    begin
      int diffs;
      diffs = 0;
      for (int a = 0; a < 128; a++) if (ram[a] !== snap[a]) diffs++;
      check_output("full_unchanged", 32'(diffs), 32'd0);
    end

    // Overlap with dst > src replicates the leading bytes
    apply_stimulus(10, 11, 3, 1'b0, 8'h00);
    wait_idle();
    check_output("overlap_11", 32'(ram[11]), 32'hA0);
    check_output("overlap_13", 32'(ram[13]), 32'hA0);
    check_model_mem();

    // start ignored mid-transfer and in the DONE cycle
    apply_stimulus(30, 40, 4, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    start = 1'b1; src_addr = 7'd99; dst_addr = 7'd100; len = 8'd1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    check_output("restart_done_pulses", 32'(done_cnt), 32'd1);
    check_output("restart_busy_cycles", 32'(busy_cnt), 32'd8);
    check_output("restart_dst", 32'(ram[43]), 32'(init_val(33)));
    check_output("restart_no_stray", 32'(ram[100]), 32'(init_val(100)));
    check_model_mem();

    // Reset after the third of eight writes
    apply_stimulus(70, 90, 8, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_en", 32'(mem_en), 32'd0);
    wait_idle();
    check_output("rst_no_done", 32'(done_cnt), 32'd0);
    for (int k = 0; k < 3; k++) check_output("rst_written", 32'(ram[90 + k]), 32'(init_val(70 + k)));
    check_output("rst_untouched", 32'(ram[93]), 32'(init_val(93)));
    check_model_mem();

    // Fill request; a plain copy when fill mode is not built in
    apply_stimulus(10, 20, 5, 1'b1, 8'h5A);
    wait_idle();
`ifdef RAM_COPIER_FILL_EN
    check_output("fill_busy_cycles", 32'(busy_cnt), 32'd5);
    check_output("fill_reads", 32'(rd_cnt), 32'd0);
    for (int k = 0; k < 5; k++) check_output("fill_dst", 32'(ram[20 + k]), 32'h5A);
`else
    check_output("fill_busy_cycles", 32'(busy_cnt), 32'd10);
    check_output("fill_reads", 32'(rd_cnt), 32'd5);
    check_output("fill_copy_20", 32'(ram[20]), 32'hA0);
    check_output("fill_copy_23", 32'(ram[23]), 32'hA0);
    check_output("fill_copy_24", 32'(ram[24]), 32'(init_val(14)));
`endif
    check_model_mem();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_copier.md
# ram_copier

Initiator-side sequencer for the team's 128x8 single-port synchronous RAM: on a start strobe it copies a block of bytes from a source region to a destination region by driving the RAM's address, enable, write-enable and write-data ports, and consuming its registered read data. It sits between control logic and the RAM. Control logic gets a simple start/busy/done handshake without sequencing individual memory cycles.

## Interface
- AW, 7, RAM address width; depth is 2^AW.
- DW, 8, RAM data width.
- clk  input  1  rising-edge clock, shared with the RAM.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- src_addr  input  AW  first source address.
- dst_addr  input  AW  first destination address.
- len  input  AW+1  byte count, 0..2^AW.
- fill  input  1  fill-mode select; used only with RAM_COPIER_FILL_EN.
- pattern  input  DW  fill byte; used only with RAM_COPIER_FILL_EN.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle completion pulse.
- mem_addr  output  AW  RAM address.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  DW  RAM write data.
- mem_rdata  input  DW  RAM read data, registered, valid the cycle after a read cycle.

## Operation
- States:
  - IDLE: waits for start.
  - READ: en=1, we=0, addr=src+i.
  - WRITE: en=1, we=1, addr=dst+i, wdata=mem_rdata.
  - DONE: single cycle.
- Transitions:
  - IDLE→READ when start=1 and len≠0; src, dst and len are latched and i is cleared.
  - IDLE→DONE when start=1 and len=0; no memory access is made.
  - READ→WRITE unconditionally.
  - WRITE→READ with i+1 when i+1<len.
  - WRITE→DONE when i+1=len.
  - DONE→IDLE.
- Addresses are computed modulo 2^AW, so src+i and dst+i wrap past 127 to 0.
- The byte counter i is AW+1 bits wide, so len=128 copies the whole memory.
- Copy is strictly forward, one byte at a time, with each read completed before its write.
  - Overlapping regions with dst>src therefore replicate the leading bytes. This is defined behaviour.
- start outside IDLE is ignored, including in the DONE cycle. Inputs may change freely once latched.
- In IDLE and DONE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, internal counter/addresses=0.
- Reset mid-transfer takes effect on the next edge and returns to IDLE with no done pulse.
  - Bytes already written remain written.
- All outputs are registered decodes of state, or combinational from state registers only. There is no combinational path from start to the mem_* outputs.
- The start edge is E0. The first READ cycle follows E0.
- Copy of N bytes: busy high for exactly 2N cycles, then done high for 1 cycle with busy=0.
- len=0: busy stays 0 and done pulses in the cycle after E0.
- mem_rdata is consumed in the WRITE cycle directly after its READ cycle, matching the RAM's one-cycle read latency.

## Configuration
- RAM_COPIER_FILL_EN defined:
  - start with fill=1 runs fill mode. The FSM skips READ and goes IDLE→WRITE→WRITE…→DONE.
  - Writes go to dst+i with wdata=pattern latched at start.
  - Fill takes N cycles of busy; src is ignored.
- RAM_COPIER_FILL_EN undefined:
  - fill and pattern are ignored.
  - Every request is a copy.

## Structure
- Shared package ram_pkg holds:
  - AW and DW defaults, and DEPTH=2^AW.
  - The state encoding constants IDLE/READ/WRITE/DONE, also reused by other RAM initiators.
- No sub-module. Single FSM plus counter.
- The bench instantiates the existing RAM as the responder behind ram_copier.

## Test plan
- Preload mem[10..13]=A0,A1,A2,A3; start src=10 dst=50 len=4 → busy high 8 cycles, done 1 cycle; mem[50..53]=A0..A3; mem[10..13] unchanged.
- Wrap: preload mem[126],mem[127],mem[0]=11,22,33; start src=126 dst=60 len=3 → mem[60..62]=11,22,33. A second case with dst=127 len=2 writes mem[127] and mem[0].
- len=0 → no mem_en assertion, busy stays 0, done pulses in the cycle after start. len=128 src=0 dst=0 → 256 busy cycles, memory unchanged.
- start pulsed again mid-transfer and in the DONE cycle → ignored; exactly one done pulse; destination contents as for a single request.
- rst=0 asserted after 3 of 8 bytes → next cycle IDLE, mem_en=0, busy=0, no done; first 3 destination bytes written, rest untouched.
- With RAM_COPIER_FILL_EN: fill=1 pattern=5A dst=20 len=5 → busy 5 cycles, mem[20..24]=5A, no read cycles. Without the macro, the same stimulus performs a copy.
